// File: rtl/led_pulse_driver_if.sv
// Bus bundle between the event source and the LED pulse driver.
interface led_pulse_driver_if;
  localparam int unsigned PEND_W = 4;

  logic              event_pulse;
  logic              led_out;
  logic              busy;
  logic              dropped;
  logic [PEND_W-1:0] pending;

  modport master (output event_pulse, input led_out, busy, dropped, pending);
  modport slave  (input event_pulse, output led_out, busy, dropped, pending);
endinterface

// File: rtl/led_pulse_driver.sv
// Stretches single-cycle events into fixed ON blinks followed by an enforced OFF gap.
// Define LED_PULSE_QUEUE_EN to queue (up to 15) events that arrive while busy.
module led_pulse_driver #(
  parameter int unsigned MS_TICKS = 12000,
  parameter int unsigned ON_MS    = 50,
  parameter int unsigned OFF_MS   = 50
) (
  input  logic clk,
  input  logic rst,
  led_pulse_driver_if.slave bus
);

  localparam int unsigned PRE_W  = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam int unsigned MS_W   = 8;
  localparam int unsigned PEND_W = 4;
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(15);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [MS_W-1:0]  ms_cnt;
  logic             led_q;
  logic             busy_q;
  logic             dropped_q;

  logic             pre_last_c;
  logic [MS_W-1:0]  ms_limit_c;
  logic             term_c;
  logic             late_ev_c;
  logic             pend_nz_c;

`ifdef LED_PULSE_QUEUE_EN
  logic [PEND_W-1:0] pend_q;
  assign pend_nz_c   = (pend_q != '0);
  assign bus.pending = pend_q;
`else
  assign pend_nz_c   = 1'b0;
  assign bus.pending = '0;
`endif

  // Terminal count of the current timed state, and events that arrive while already busy
  always_comb begin
    pre_last_c = (pre == PRE_W'(MS_TICKS - 1));
    ms_limit_c = (state == ON) ? MS_W'(ON_MS - 1) : MS_W'(OFF_MS - 1);
    term_c     = (state != IDLE) && pre_last_c && (ms_cnt == ms_limit_c);
    // the last OFF cycle can restart a blink directly, so an event there is not "late"
    late_ev_c  = bus.event_pulse && (state != IDLE) && !((state == OFF) && term_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pre       <= '0;
      ms_cnt    <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
`ifdef LED_PULSE_QUEUE_EN
      pend_q    <= '0;
`endif
    end else begin
      dropped_q <= 1'b0;

      // Counters restart on every state entry; idle keeps them parked at zero
      if ((state == IDLE) || term_c) begin
        pre    <= '0;
        ms_cnt <= '0;
      end else if (pre_last_c) begin
        pre    <= '0;
        ms_cnt <= ms_cnt + MS_W'(1);
      end else begin
        pre    <= pre + PRE_W'(1);
      end

      case (state)
        IDLE: begin
          if (bus.event_pulse) begin
            state  <= ON;
            led_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        ON: begin
          if (term_c) begin
            state <= OFF;
            led_q <= 1'b0;
          end
        end
        OFF: begin
          if (term_c) begin
            if (pend_nz_c || bus.event_pulse) begin
              state <= ON;
              led_q <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          led_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase

`ifdef LED_PULSE_QUEUE_EN
      // An event coinciding with a dequeue cancels out and leaves the count alone
      if (late_ev_c) begin
        if (pend_q == PEND_MAX) dropped_q <= 1'b1;
        else                    pend_q    <= pend_q + PEND_W'(1);
      end else if ((state == OFF) && term_c && pend_nz_c && !bus.event_pulse) begin
        pend_q <= pend_q - PEND_W'(1);
      end
`else
      if (late_ev_c) dropped_q <= 1'b1;
`endif
    end
  end

  assign bus.led_out = led_q;
  assign bus.busy    = busy_q;
  assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_led_pulse_driver.sv
// Directed and random checks of led_pulse_driver against a phase-length reference model.
module tb_led_pulse_driver;

  localparam int unsigned MS_TICKS = 4;
  localparam int unsigned ON_MS    = 2;
  localparam int unsigned OFF_MS   = 1;
  localparam int ON_LEN  = ON_MS * MS_TICKS;
  localparam int OFF_LEN = OFF_MS * MS_TICKS;
`ifdef LED_PULSE_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_pulse_driver_if bus ();

  led_pulse_driver #(.MS_TICKS(MS_TICKS), .ON_MS(ON_MS), .OFF_MS(OFF_MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int drops = 0;
  int blinks = 0;
  logic prev_led = 1'b0;

  // Reference model: remaining cycles in the current lit/gap phase
  logic m_busy = 1'b0;
  logic m_led  = 1'b0;
  logic m_drop = 1'b0;
  int   m_pend = 0;
  int   m_rem  = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic late_event();
    if (QUEUE && m_pend < 15) m_pend++;
    else                      m_drop = 1'b1;
  endtask

  task automatic model_edge(input logic e, input logic r);
    if (r) begin
      m_busy = 0; m_led = 0; m_drop = 0; m_pend = 0; m_rem = 0;
    end else begin
      m_drop = 1'b0;
      if (!m_busy) begin
        if (e) begin m_busy = 1; m_led = 1; m_rem = ON_LEN; end
      end else begin
        m_rem--;
        if (m_rem == 0 && !m_led) begin
          if (m_pend > 0) begin
            if (!e) m_pend--;
            m_led = 1; m_rem = ON_LEN;
          end else if (e) begin
            m_led = 1; m_rem = ON_LEN;
          end else begin
            m_busy = 0;
          end
        end else begin
          if (m_rem == 0) begin m_led = 0; m_rem = OFF_LEN; end
          if (e) late_event();
        end
      end
    end
  endtask

  task automatic step(input logic e, input logic r);
    bus.event_pulse = e;
    rst = r;
    @(posedge clk);
    #1;
    model_edge(e, r);
    chk("led_out", 8'(bus.led_out), 8'(m_led));
    chk("busy",    8'(bus.busy),    8'(m_busy));
    chk("dropped", 8'(bus.dropped), 8'(m_drop));
    chk("pending", 8'(bus.pending), 8'(m_pend));
    if (bus.dropped === 1'b1) drops++;
    if (bus.led_out === 1'b1 && prev_led === 1'b0) blinks++;
    prev_led = bus.led_out;
    bus.event_pulse = 1'b0;
  endtask

  initial begin
    int d0;
    int b0;
    bus.event_pulse = 1'b0;

    // reset state
    step(0, 1);
    step(0, 1);
    chk("rst_led", 8'(bus.led_out), 8'd0);
    chk("rst_pending", 8'(bus.pending), 8'd0);

    // single blink timeline: 8 lit, 4 gap, then idle
    for (int i = 0; i < 9; i++) step(0, 0);
    d0 = drops;
    step(1, 0);
    chk("blink_on0", 8'(bus.led_out), 8'd1);
    for (int i = 1; i < ON_LEN; i++) begin
      step(0, 0);
      chk("blink_on", 8'(bus.led_out), 8'd1);
    end
    for (int i = 0; i < OFF_LEN; i++) begin
      step(0, 0);
      chk("blink_off_led", 8'(bus.led_out), 8'd0);
      chk("blink_off_busy", 8'(bus.busy), 8'd1);
    end
    step(0, 0);
    chk("blink_idle", 8'(bus.busy), 8'd0);
    chk("blink_nodrop", 8'(drops - d0), 8'd0);

    // three events during ON
    step(0, 0);
    b0 = blinks;
    step(1, 0);
    step(1, 0); step(1, 0); step(1, 0);
    chk("q3_pending", 8'(bus.pending), QUEUE ? 8'd3 : 8'd0);
    for (int i = 0; i < 4 * (ON_LEN + OFF_LEN) + 4; i++) step(0, 0);
    chk("q3_blinks", 8'(blinks - b0), QUEUE ? 8'd4 : 8'd1);
    chk("q3_idle", 8'(bus.busy), 8'd0);

    // 17 back-to-back events after a trigger
    d0 = drops;
    step(1, 0);
    for (int i = 0; i < 17; i++) step(1, 0);
    chk("sat_pending", 8'(bus.pending), QUEUE ? 8'd15 : 8'd0);
    chk("sat_drops", 8'(drops - d0), QUEUE ? 8'd1 : 8'd16);
    step(0, 1);
    step(0, 0);

    // reset mid-ON with two queued, event ignored while in reset
    step(1, 0); step(1, 0); step(1, 0);
    chk("mid_pending", 8'(bus.pending), QUEUE ? 8'd2 : 8'd0);
    step(1, 1);
    chk("mid_rst_led", 8'(bus.led_out), 8'd0);
    chk("mid_rst_busy", 8'(bus.busy), 8'd0);
    chk("mid_rst_pending", 8'(bus.pending), 8'd0);
    b0 = blinks;
    for (int i = 0; i < 30; i++) step(0, 0);
    chk("mid_no_blink", 8'(blinks - b0), 8'd0);
    step(1, 0);
    chk("resume_led", 8'(bus.led_out), 8'd1);
    for (int i = 0; i < ON_LEN + OFF_LEN + 2; i++) step(0, 0);

    // event on last gap cycle restarts directly
    d0 = drops;
    step(1, 0);
    for (int i = 0; i < ON_LEN + OFF_LEN - 1; i++) step(0, 0);
    step(1, 0);
    chk("last_gap_led", 8'(bus.led_out), 8'd1);
    chk("last_gap_pending", 8'(bus.pending), 8'd0);
    chk("last_gap_drops", 8'(drops - d0), 8'd0);
    for (int i = 0; i < ON_LEN + OFF_LEN + 2; i++) step(0, 0);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) step(($urandom % 5) == 0, ($urandom % 97) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
